control_unit: RTL
=================

Name: control_unit

Overview:
- Multicycle FSM sequencer for the 16-bit CPU datapath.
- Generates every mux select, register write enable, ALU op and memory strobe that the datapath expects, replacing hand-driven control.
- Inputs are `opcode` (from IR) and `status_reg`.
- Sits beside `CPU` inside the top level; memory handshakes through `mem_ready`.

Parameters:
- WORD_SIZE, 16, datapath/status width
- ALU_OP_SIZE, 3, ALU operation field width
- OPCODE_SIZE, 5, opcode width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- opcode  in  OPCODE_SIZE  IR[15:11]
- status_reg  in  WORD_SIZE  flags; bit 0 = Z
- mem_ready  in  1  memory completes current access this cycle
- ALU_in2_mux  out  1  0 = IR immediate, 1 = reg_buff2
- mem_out_mux  out  1  0 = reg_buff1 to memory data
- PC_mux  out  2  0 = PC+1, 1 = IR branch target
- memory_addr_mux  out  2  0 = PC, 2 = IR address field
- data_in_mux  out  2  0 = ALU_out, 1 = memory_out, 2 = IR immediate
- reg_buff1_write, reg_buff2_write, status_reg_write, ALU_out_write, reg_write, PC_write, IR_write  out  1 each  datapath write enables
- ALU_op  out  ALU_OP_SIZE  ALU operation
- mem_read, mem_write  out  1  memory request strobes
- halted  out  1  core stopped

Behaviour:
- Opcode classes:
  - ALU_R 00xxx
  - ALU_I 01xxx
  - JMP 10000
  - BZ 10001
  - LOAD 11100
  - STORE 11101
  - LOAD_I 11110
  - HALT 11111
  - All others undefined, executed as NOP.
- States: FETCH, DECODE, EXEC, MEM, WB, HALTED.
- Outputs are a combinational function of state, class and `mem_ready`. Every output not named in a state is 0.
- Reset (async): state = FETCH; all outputs 0 while reset is high, including `halted`. First fetch request is issued in the first cycle after reset deasserts.
- FETCH:
  - `memory_addr_mux`=0, `mem_read`=1.
  - If `mem_ready`=1: `IR_write`=1, `PC_write`=1, `PC_mux`=0, go to DECODE.
  - Otherwise hold with all writes 0.
- DECODE:
  - `reg_buff1_write`=1, `reg_buff2_write`=1.
  - Next state: ALU_R/ALU_I/JMP/BZ → EXEC; LOAD/STORE → MEM; LOAD_I → WB; HALT → HALTED; undefined → FETCH.
- EXEC, ALU classes:
  - `ALU_op`=opcode[2:0].
  - `ALU_in2_mux`=1 for ALU_R, 0 for ALU_I.
  - `ALU_out_write`=1, `status_reg_write`=1.
  - Go to WB.
- EXEC, JMP: `PC_write`=1, `PC_mux`=1, go to FETCH.
- EXEC, BZ:
  - If status_reg[0]=1: `PC_write`=1, `PC_mux`=1.
  - Otherwise no writes.
  - Go to FETCH.
  - Z is sampled in EXEC, so it reflects the last ALU instruction.
- MEM, LOAD:
  - `memory_addr_mux`=2, `mem_read`=1.
  - On `mem_ready`: `reg_write`=1, `data_in_mux`=1, go to FETCH.
- MEM, STORE:
  - `memory_addr_mux`=2, `mem_out_mux`=0, `mem_write`=1.
  - On `mem_ready`: go to FETCH.
- Memory request rules:
  - `mem_read`/`mem_write` and the address select stay stable until `mem_ready`.
  - `mem_read` and `mem_write` are never both 1.
  - `mem_ready` outside FETCH/MEM is ignored.
- WB: `reg_write`=1; `data_in_mux`=0 for ALU classes, 2 for LOAD_I; go to FETCH.
- HALTED: `halted`=1, all writes/strobes 0; state is sticky until reset.
- Latency with zero-wait memory (`mem_ready` tied 1):
  - ALU: 4 cycles.
  - LOAD_I, LOAD, STORE, JMP, BZ: 3 cycles.
  - Undefined: 2 cycles.
  - Each wait cycle adds 1.
- Reset mid-instruction: outputs drop to 0 asynchronously; the partially executed instruction has no further effect.

Decomposition:
- Package `cpu_pkg` holds:
  - WORD_SIZE, ALU_OP_SIZE, REG_ADDR_SIZE
  - opcode constants and class enum
  - state enum
  - mux-select constants (PC_SEL_INC/BRANCH, ADDR_SEL_PC/IR, DIN_SEL_ALU/MEM/IMM, IN2_SEL_IMM/REG)
- One combinational sub-module, `opcode_decode`: opcode → class plus `ALU_op`.
- FSM and output logic stay in `control_unit`.

Test Plan:
- Reset asserted mid-EXEC of an ALU_R instruction → all enables 0 immediately; after release, `mem_read`=1 with `memory_addr_mux`=0 in the first cycle.
- Program LOAD_I r1,11; LOAD_I r3,4; ADD r0,r1,r3 (0000000011001000) with `mem_ready`=1 → cycle counts 3/3/4, `ALU_in2_mux`=1 and `ALU_op`=000 in EXEC, `reg_write`+`data_in_mux`=0 in WB.
- STORE (11101…) with `mem_ready` low for 3 cycles in MEM → `mem_write`=1 and `memory_addr_mux`=2 held 4 cycles, then FETCH; no `reg_write`.
- BZ with status_reg=0x0001, then BZ with status_reg=0x0000 → `PC_write`=1, `PC_mux`=1 only for the first; both 3 cycles.
- LOAD with 2 wait states → `reg_write`=1, `data_in_mux`=1 only in the `mem_ready` cycle.
- Undefined opcode 10010 → DECODE→FETCH, zero writes beyond fetch/buffers; HALT → `halted`=1 sticky for 20 cycles with `mem_ready` toggling, cleared only by reset.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU control path: widths, opcodes,
// instruction classes, sequencer states and datapath mux select codes.
package cpu_pkg;

    localparam int WORD_SIZE     = 16;
    localparam int ALU_OP_SIZE   = 3;
    localparam int OPCODE_SIZE   = 5;
    localparam int REG_ADDR_SIZE = 3;

    // Fully specified opcodes; ALU classes are matched on the top two bits.
    localparam logic [OPCODE_SIZE-1:0] OP_JMP    = 5'b10000;
    localparam logic [OPCODE_SIZE-1:0] OP_BZ     = 5'b10001;
    localparam logic [OPCODE_SIZE-1:0] OP_LOAD   = 5'b11100;
    localparam logic [OPCODE_SIZE-1:0] OP_STORE  = 5'b11101;
    localparam logic [OPCODE_SIZE-1:0] OP_LOAD_I = 5'b11110;
    localparam logic [OPCODE_SIZE-1:0] OP_HALT   = 5'b11111;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_JMP,
        CLS_BZ,
        CLS_LOAD,
        CLS_STORE,
        CLS_LOAD_I,
        CLS_HALT,
        CLS_UNDEF
    } op_class_t;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
    } state_t;

    // Datapath mux select encodings.
    localparam logic [1:0] PC_SEL_INC      = 2'd0;
    localparam logic [1:0] PC_SEL_BRANCH   = 2'd1;
    localparam logic [1:0] ADDR_SEL_PC     = 2'd0;
    localparam logic [1:0] ADDR_SEL_IR     = 2'd2;
    localparam logic [1:0] DIN_SEL_ALU     = 2'd0;
    localparam logic [1:0] DIN_SEL_MEM     = 2'd1;
    localparam logic [1:0] DIN_SEL_IMM     = 2'd2;
    localparam logic       IN2_SEL_IMM     = 1'b0;
    localparam logic       IN2_SEL_REG     = 1'b1;
    localparam logic       MEM_OUT_SEL_BUF1 = 1'b0;

    function automatic logic is_alu_class(input op_class_t c);
        return (c == CLS_ALU_R) || (c == CLS_ALU_I);
    endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode classifier: maps IR[15:11] to an instruction class
// and extracts the ALU operation field.
module opcode_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_SIZE-1:0] opcode,
    output op_class_t              op_class,
    output logic [ALU_OP_SIZE-1:0] alu_op
);

    // Classify; anything not listed falls through to CLS_UNDEF (run as NOP).
    always_comb begin
        op_class = CLS_UNDEF;
        alu_op   = opcode[ALU_OP_SIZE-1:0];
        case (opcode[OPCODE_SIZE-1:OPCODE_SIZE-2])
            2'b00:   op_class = CLS_ALU_R;
            2'b01:   op_class = CLS_ALU_I;
            default: begin
                case (opcode)
                    OP_JMP:    op_class = CLS_JMP;
                    OP_BZ:     op_class = CLS_BZ;
                    OP_LOAD:   op_class = CLS_LOAD;
                    OP_STORE:  op_class = CLS_STORE;
                    OP_LOAD_I: op_class = CLS_LOAD_I;
                    OP_HALT:   op_class = CLS_HALT;
                    default:   op_class = CLS_UNDEF;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multicycle sequencer for the 16-bit CPU. Outputs are a combinational
// function of state, instruction class and mem_ready, forced to zero while
// reset is held. Memory handshake: a request (mem_read or mem_write plus the
// address select) is held stable until the cycle in which mem_ready is 1;
// that cycle completes the access. mem_ready is ignored in other states.
module control_unit
    import cpu_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic [WORD_SIZE-1:0]   status_reg,
    input  logic                   mem_ready,
    output logic                   ALU_in2_mux,
    output logic                   mem_out_mux,
    output logic [1:0]             PC_mux,
    output logic [1:0]             memory_addr_mux,
    output logic [1:0]             data_in_mux,
    output logic                   reg_buff1_write,
    output logic                   reg_buff2_write,
    output logic                   status_reg_write,
    output logic                   ALU_out_write,
    output logic                   reg_write,
    output logic                   PC_write,
    output logic                   IR_write,
    output logic [ALU_OP_SIZE-1:0] ALU_op,
    output logic                   mem_read,
    output logic                   mem_write,
    output logic                   halted,
    output state_t                 state_dbg
);

    state_t                 state_q, state_d;
    op_class_t              op_class;
    logic [ALU_OP_SIZE-1:0] dec_alu_op;
    logic                   z_flag;
    logic                   unused_status;

    assign z_flag        = status_reg[0];
    assign unused_status = ^status_reg[WORD_SIZE-1:1];
    assign state_dbg     = state_q;

    opcode_decode u_decode (
        .opcode   (opcode),
        .op_class (op_class),
        .alu_op   (dec_alu_op)
    );

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op_class)
                    CLS_ALU_R, CLS_ALU_I, CLS_JMP, CLS_BZ: state_d = ST_EXEC;
                    CLS_LOAD, CLS_STORE:                   state_d = ST_MEM;
                    CLS_LOAD_I:                            state_d = ST_WB;
                    CLS_HALT:                              state_d = ST_HALTED;
                    default:                               state_d = ST_FETCH;
                endcase
            end
            ST_EXEC:   state_d = is_alu_class(op_class) ? ST_WB : ST_FETCH;
            ST_MEM:    if (mem_ready) state_d = ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
            ST_HALTED: state_d = ST_HALTED;
            default:   state_d = ST_FETCH;
        endcase
    end

    // State register; reset returns to FETCH and abandons any instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // Control outputs per state; everything not named stays 0.
    always_comb begin
        ALU_in2_mux      = IN2_SEL_IMM;
        mem_out_mux      = MEM_OUT_SEL_BUF1;
        PC_mux           = PC_SEL_INC;
        memory_addr_mux  = ADDR_SEL_PC;
        data_in_mux      = DIN_SEL_ALU;
        reg_buff1_write  = 1'b0;
        reg_buff2_write  = 1'b0;
        status_reg_write = 1'b0;
        ALU_out_write    = 1'b0;
        reg_write        = 1'b0;
        PC_write         = 1'b0;
        IR_write         = 1'b0;
        ALU_op           = '0;
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        halted           = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    memory_addr_mux = ADDR_SEL_PC;
                    mem_read        = 1'b1;
                    if (mem_ready) begin
                        IR_write = 1'b1;
                        PC_write = 1'b1;
                        PC_mux   = PC_SEL_INC;
                    end
                end
                ST_DECODE: begin
                    reg_buff1_write = 1'b1;
                    reg_buff2_write = 1'b1;
                end
                ST_EXEC: begin
                    if (is_alu_class(op_class)) begin
                        ALU_op           = dec_alu_op;
                        ALU_in2_mux      = (op_class == CLS_ALU_R) ? IN2_SEL_REG : IN2_SEL_IMM;
                        ALU_out_write    = 1'b1;
                        status_reg_write = 1'b1;
                    end else if (op_class == CLS_JMP || (op_class == CLS_BZ && z_flag)) begin
                        PC_write = 1'b1;
                        PC_mux   = PC_SEL_BRANCH;
                    end
                end
                ST_MEM: begin
                    if (op_class == CLS_LOAD) begin
                        memory_addr_mux = ADDR_SEL_IR;
                        mem_read        = 1'b1;
                        if (mem_ready) begin
                            reg_write   = 1'b1;
                            data_in_mux = DIN_SEL_MEM;
                        end
                    end else if (op_class == CLS_STORE) begin
                        memory_addr_mux = ADDR_SEL_IR;
                        mem_out_mux     = MEM_OUT_SEL_BUF1;
                        mem_write       = 1'b1;
                    end
                end
                ST_WB: begin
                    reg_write   = 1'b1;
                    data_in_mux = (op_class == CLS_LOAD_I) ? DIN_SEL_IMM : DIN_SEL_ALU;
                end
                ST_HALTED: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
